// File: rtl/rst_ctrl_sonata.sv
// Reset sequencer: syncs PLL lock/button, debounces button, releases rst_sys_no then rst_core_no from flops.
// Define RST_CTRL_CAUSE_EN to build the sticky reset_cause_o logic; otherwise it reads 3'b000.
module rst_ctrl_sonata #(
  parameter int unsigned SyncStages      = 2,
  parameter int unsigned DebounceCycles  = 4096,
  parameter int unsigned StretchCycles   = 16,
  parameter int unsigned CoreDelayCycles = 8
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       pll_locked_i,
  input  logic       ext_rst_ni,
  input  logic       ndm_reset_req_i,
  input  logic       cause_clr_i,
  output logic       rst_sys_no,
  output logic       rst_core_no,
  output logic [2:0] reset_cause_o
);

  localparam int unsigned MaxCnt = (StretchCycles > CoreDelayCycles) ? StretchCycles : CoreDelayCycles;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);
  localparam int unsigned DbW    = $clog2(DebounceCycles + 1);

  localparam logic [CntW-1:0] StretchLast = CntW'(StretchCycles - 1);
  localparam logic [CntW-1:0] CoreLast    = CntW'(CoreDelayCycles - 1);
  localparam logic [CntW-1:0] CntMax      = CntW'(MaxCnt);
  localparam logic [DbW-1:0]  DbLast      = DbW'(DebounceCycles - 1);

  typedef enum logic [1:0] {
    Hold,
    Stretch,
    SysUp,
    Run
  } state_e;

  logic [SyncStages-1:0] lock_sync_q;
  logic [SyncStages-1:0] btn_sync_q;
  logic                  locked_sync;
  logic                  btn_sync;

  logic                  btn_db_q, btn_db_d;
  logic [DbW-1:0]        db_cnt_q, db_cnt_d;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                  rst_sys_q, rst_sys_d;
  logic                  rst_core_q, rst_core_d;
  logic                  request;

  // Lock synchroniser idles "unlocked", button synchroniser idles "released".
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
    end else begin
      lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_locked_i};
      btn_sync_q  <= {btn_sync_q[SyncStages-2:0], ext_rst_ni};
    end
  end

  assign locked_sync = lock_sync_q[SyncStages-1];
  assign btn_sync    = btn_sync_q[SyncStages-1];

  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_sync != btn_db_q) begin
      if (db_cnt_q >= DbLast) begin
        btn_db_d = ~btn_db_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign request = ~locked_sync | ~btn_db_q | ndm_reset_req_i;
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  // Request is checked first in every state so it always beats counter expiry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rst_sys_d  = 1'b0;
    rst_core_d = 1'b0;
    case (state_q)
      Hold: begin
        cnt_d = '0;
        if (!request) begin
          state_d = Stretch;
        end
      end
      Stretch: begin
        if (request) begin
          state_d = Hold;
          cnt_d   = '0;
        end else if (cnt_q == StretchLast) begin
          state_d   = SysUp;
          cnt_d     = '0;
          rst_sys_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      SysUp: begin
        if (request) begin
          state_d = Hold;
          cnt_d   = '0;
        end else if (cnt_q == CoreLast) begin
          state_d    = Run;
          cnt_d      = '0;
          rst_sys_d  = 1'b1;
          rst_core_d = 1'b1;
        end else begin
          cnt_d     = cnt_inc;
          rst_sys_d = 1'b1;
        end
      end
      Run: begin
        if (request) begin
          state_d = Hold;
          cnt_d   = '0;
        end else begin
          rst_sys_d  = 1'b1;
          rst_core_d = 1'b1;
        end
      end
      default: begin
        state_d = Hold;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      btn_db_q   <= 1'b1;
      db_cnt_q   <= '0;
      state_q    <= Hold;
      cnt_q      <= '0;
      rst_sys_q  <= 1'b0;
      rst_core_q <= 1'b0;
    end else begin
      btn_db_q   <= btn_db_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_sys_q  <= rst_sys_d;
      rst_core_q <= rst_core_d;
    end
  end

  assign rst_sys_no  = rst_sys_q;
  assign rst_core_no = rst_core_q;

`ifdef RST_CTRL_CAUSE_EN
  logic [2:0] src;
  logic [2:0] src_q;
  logic [2:0] cause_q, cause_d;

  // Bit order {ndm, button, lock_loss}; src_q starts matching the reset value of each source.
  assign src     = {ndm_reset_req_i, ~btn_db_q, ~locked_sync};
  assign cause_d = (cause_clr_i ? 3'b000 : cause_q) | (src & ~src_q);

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      src_q   <= 3'b001;
      cause_q <= 3'b000;
    end else begin
      src_q   <= src;
      cause_q <= cause_d;
    end
  end

  assign reset_cause_o = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr_i;
  assign reset_cause_o    = 3'b000;
`endif

endmodule
